dly_pipe_var: RTL and testbench
===============================

# dly_pipe_var

Multi-channel, parametrised pipeline delay line with a runtime-selectable depth, clock enable and valid tracking. It is the general successor to the fixed-depth flop chain used to align datapaths. It sits between producers and consumers whose relative latency varies with configuration, and it must not emit stale data after a depth change.

## Interface
Parameters:
- WIDTH, 16, bits per channel
- CHANNELS, 1, number of parallel lanes sharing one delay setting
- MAX_DEPTH, 8, maximum delay in enabled cycles (≥1)
- DW, $clog2(MAX_DEPTH+1), width of dly port (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; pipeline advances only when 1
- dly  in  DW  requested delay in ce-cycles
- in_valid  in  1  qualifies d
- d  in  CHANNELS*WIDTH  input lanes; lane k at [k*WIDTH +: WIDTH]
- q  out  CHANNELS*WIDTH  delayed lanes
- out_valid  out  1  q is valid
- filling  out  1  1 while pipe refills after reset or depth change

## Operation
- Effective depth: dly_eff = clamp(dly), with 0 → 1 and values > MAX_DEPTH → MAX_DEPTH.
- Storage: per lane, MAX_DEPTH registers tap[0..MAX_DEPTH-1], plus one shared valid chain vtap[0..MAX_DEPTH-1]. On ce: tap[0]<=d, vtap[0]<=in_valid, tap[i]<=tap[i-1], vtap[i]<=vtap[i-1]. With ce=0, all registers hold.
- Output: q = tap[dly_eff-1] and raw valid = vtap[dly_eff-1], both combinational muxes from registers.
- FSM (dly_pipe_pkg::state_t):
  - FILL: set by rst or by any cycle where dly_eff != dly_q (registered previous dly_eff). In FILL, fill_cnt increments on each ce. The FSM goes to RUN on the ce cycle where fill_cnt == dly_eff-1.
  - RUN: stays in RUN until rst or a depth change.
- A depth change is detected every cycle, regardless of ce. It resets fill_cnt to 0 and forces FILL. A change while already in FILL restarts the count.
- out_valid = (state==RUN) && vtap[dly_eff-1].
- filling = (state==FILL).
- Data registers are not cleared on a depth change. Only qualification is suppressed.

## Timing
- Reset values: all tap=0, vtap=0, fill_cnt=0, dly_q=clamp(dly) sampled in the reset cycle, state=FILL. Therefore q=0, out_valid=0, filling=1.
- Latency: a sample accepted on ce edge n appears at q after the dly_eff-th ce edge counted from n, with n itself counting as the first. At dly_eff=1 this is one registered stage.
- After reset or a depth change, out_valid first asserts after the dly_eff-th ce edge. No earlier sample is ever qualified.
- Simultaneous rst and depth change: rst wins.
- Simultaneous change and ce: the shift still happens and the count restarts at 0.
- ce low for arbitrary periods: latency in ce-cycles is unchanged and out_valid holds its value.

## Configuration
- DLY_PIPE_ZERO_INVALID_EN:
  - Defined: q is forced to all zeros whenever out_valid=0.
  - Undefined: q always shows the raw tap, including stale data during FILL. This saves a CHANNELS*WIDTH AND gate array.

## Structure
- dly_pipe_pkg holds:
  - state_t enum {FILL, RUN}
  - function clamp_dly(dly, MAX_DEPTH)
  - no width constants; those are parameters.
- Sub-module dly_pipe_lane (WIDTH, MAX_DEPTH): one lane's shift chain plus its tap mux. It is instantiated CHANNELS times by a generate loop.
- The valid chain, FSM and fill counter live once in the top module.

## Test plan
- Reset, then dly=3, CHANNELS=2, ce=1, in_valid=1, d = lane0 counter 1,2,3… and lane1 = lane0+100 → q lane0=1 / lane1=101 with out_valid=1 exactly 3 cycles after the first sample. filling drops in the same cycle.
- Steady at dly=3, switch to dly=5 mid-stream → out_valid=0 and filling=1 for 5 ce-cycles, then q resumes with 5-cycle latency and no value is skipped or duplicated as counted from the new tap.
- dly=0 → behaves as 1 (one-cycle latency). dly=MAX_DEPTH+3 → behaves as MAX_DEPTH.
- ce toggling 1,0,0,1 with dly=2 → output advances only on ce=1 edges, latency is 2 ce-edges, and out_valid holds while ce=0.
- in_valid pattern 1,0,1 at dly=4 → out_valid pattern 1,0,1 four cycles later. With DLY_PIPE_ZERO_INVALID_EN defined, q=0 on the invalid beat.
- Assert rst during FILL and again during RUN → next cycle q=0, out_valid=0, filling=1, and the refill count restarts.

Source files
------------

// File: rtl/dly_pipe_pkg.sv
// Shared types and helpers for the variable-depth delay line.
package dly_pipe_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Map a requested delay onto the implementable range 1..max_depth.
  function automatic int unsigned clamp_dly(input int unsigned dly,
                                            input int unsigned max_depth);
    if (dly == 0) begin
      return 1;
    end else if (dly > max_depth) begin
      return max_depth;
    end else begin
      return dly;
    end
  endfunction

endpackage

// File: rtl/dly_pipe_lane.sv
// One lane of the delay line: a MAX_DEPTH-stage shift chain and its output tap mux.
module dly_pipe_lane #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_DEPTH = 8,
  localparam int unsigned DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic [DW-1:0]    sel,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] tap [MAX_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) tap[i] <= '0;
    end else if (ce) begin
      tap[0] <= d;
      for (int i = 1; i < MAX_DEPTH; i++) tap[i] <= tap[i-1];
    end
  end

  // sel is tap index (dly_eff-1), always within 0..MAX_DEPTH-1
  always_comb begin
    q = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (sel == DW'(i)) q = tap[i];
    end
  end

endmodule

// File: rtl/dly_pipe_var.sv
// Multi-lane delay line with runtime depth, clock enable and refill qualification.
// Optional: define DLY_PIPE_ZERO_INVALID_EN to force q to zero while out_valid is low.
module dly_pipe_var
  import dly_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned MAX_DEPTH = 8,
  localparam int unsigned DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [DW-1:0]             dly,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic                      out_valid,
  output logic                      filling
);

  logic [DW-1:0]             dly_eff;
  logic [DW-1:0]             sel;
  logic [DW-1:0]             dly_q;
  logic                      change;
  logic [MAX_DEPTH-1:0]      vtap;
  logic                      vld_raw;
  logic [CHANNELS*WIDTH-1:0] q_raw;
  logic [DW-1:0]             fill_cnt_q, fill_cnt_d;
  state_t                    state_q, state_d;

  assign dly_eff = DW'(clamp_dly(32'(dly), MAX_DEPTH));
  assign sel     = DW'(dly_eff - DW'(1));
  assign change  = (dly_eff != dly_q);

  // Shared valid chain, shifted in lockstep with the data lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      vtap <= '0;
    end else if (ce) begin
      vtap[0] <= in_valid;
      for (int i = 1; i < MAX_DEPTH; i++) vtap[i] <= vtap[i-1];
    end
  end

  always_comb begin
    vld_raw = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (sel == DW'(i)) vld_raw = vtap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      dly_q      <= dly_eff;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      dly_q      <= dly_eff;
    end
  end

  // A depth change restarts the refill even if ce is high in the same cycle
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (change) begin
      state_d    = FILL;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (ce) begin
            if (fill_cnt_q == sel) begin
              state_d    = RUN;
              fill_cnt_d = '0;
            end else begin
              fill_cnt_d = DW'(fill_cnt_q + DW'(1));
            end
          end
        end
        RUN:     state_d = RUN;
        default: state_d = FILL;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    dly_pipe_lane #(
      .WIDTH    (WIDTH),
      .MAX_DEPTH(MAX_DEPTH)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .ce (ce),
      .d  (d[k*WIDTH +: WIDTH]),
      .sel(sel),
      .q  (q_raw[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = (state_q == RUN) && vld_raw;
  assign filling   = (state_q == FILL);

`ifdef DLY_PIPE_ZERO_INVALID_EN
  assign q = out_valid ? q_raw : '0;
`else
  assign q = q_raw;
`endif

endmodule

// File: tb/tb_dly_pipe_var.sv
// Self-checking bench for dly_pipe_var: directed test-plan steps plus random traffic vs. a history model.
module tb_dly_pipe_var;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 2;
  localparam int unsigned MD = 8;
  localparam int unsigned DW = $clog2(MD + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [DW-1:0]     dly;
  logic              in_valid;
  logic [CH*W-1:0]   d;
  logic [CH*W-1:0]   q;
  logic              out_valid;
  logic              filling;

  always #5 clk = ~clk;

  dly_pipe_var #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .MAX_DEPTH(MD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .dly      (dly),
    .in_valid (in_valid),
    .d        (d),
    .q        (q),
    .out_valid(out_valid),
    .filling  (filling)
  );

  // Reference model: history of accepted samples (index 0 = newest) and ce edges since last restart
  logic [CH*W-1:0] m_hist [MD];
  logic            m_vhist [MD];
  int              m_since;
  int              m_dly_q;
  int              errors = 0;
  int              checks = 0;

  function automatic int eff(input logic [DW-1:0] v);
    int x;
    x = int'(v);
    if (x < 1) return 1;
    if (x > int'(MD)) return int'(MD);
    return x;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < int'(MD); i++) begin
        m_hist[i]  = '0;
        m_vhist[i] = 1'b0;
      end
      m_since = 0;
      m_dly_q = eff(dly);
    end else begin
      if (ce) begin
        for (int i = int'(MD) - 1; i > 0; i--) begin
          m_hist[i]  = m_hist[i-1];
          m_vhist[i] = m_vhist[i-1];
        end
        m_hist[0]  = d;
        m_vhist[0] = in_valid;
      end
      if (eff(dly) != m_dly_q) begin
        m_since = 0;
        m_dly_q = eff(dly);
      end else if (ce && m_since < 1000) begin
        m_since++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_check(input string tag);
    int              e;
    logic            ev;
    logic [CH*W-1:0] eq;
    e  = eff(dly);
    ev = (m_since >= m_dly_q) && m_vhist[e-1];
    eq = m_hist[e-1];
`ifdef DLY_PIPE_ZERO_INVALID_EN
    if (!ev) eq = '0;
`endif
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".filling"}, 32'(filling), 32'(m_since < m_dly_q));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic put(input int k);
    d = {16'(k + 100), 16'(k)};
  endtask

  initial begin
    int   cnt;
    logic prev_ov;

    rst = 1'b1; ce = 1'b0; dly = DW'(3); in_valid = 1'b0; d = '0;
    for (int i = 0; i < int'(MD); i++) begin
      m_hist[i] = 'x; m_vhist[i] = 1'bx;
    end
    m_since = 0; m_dly_q = 0;
    @(negedge clk);
    step("reset");
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_ov", 32'(out_valid), 32'd0);
    chk("reset_fill", 32'(filling), 32'd1);

    // Counter stream at depth 3, then switch to depth 5 mid-stream
    rst = 1'b0; ce = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 13) dly = DW'(5);
      put(k);
      step("stream");
      if (k == 2) chk("d3_not_yet", 32'(out_valid), 32'd0);
      if (k == 3) begin
        chk("d3_lane0", 32'(q[15:0]), 32'd1);
        chk("d3_lane1", 32'(q[31:16]), 32'd101);
        chk("d3_ov", 32'(out_valid), 32'd1);
        chk("d3_fill", 32'(filling), 32'd0);
      end
      if (k >= 13 && k <= 17) chk("d5_filling", 32'(filling), 32'd1);
      if (k >= 18) begin
        chk("d5_lane0", 32'(q[15:0]), 32'(k - 4));
        chk("d5_ov", 32'(out_valid), 32'd1);
      end
    end

    // dly=0 behaves as 1
    dly = DW'(0); cnt = 200;
    for (int k = 0; k < 4; k++) begin
      put(cnt); step("dly0");
      if (k >= 1) chk("dly0_lane0", 32'(q[15:0]), 32'(cnt));
      cnt++;
    end

    // dly above MAX_DEPTH behaves as MAX_DEPTH
    dly = DW'(MD + 3);
    for (int k = 0; k < 12; k++) begin
      put(cnt); step("dlymax");
      if (k >= int'(MD)) chk("dlymax_lane0", 32'(q[15:0]), 32'(cnt - int'(MD) + 1));
      cnt++;
    end

    // ce pattern 1,0,0,1 at depth 2: output holds while ce is low
    dly = DW'(2);
    for (int k = 0; k < 16; k++) begin
      ce = (k % 4 == 0) || (k % 4 == 3);
      put(cnt);
      prev_ov = out_valid;
      step("ce_toggle");
      if (!ce && k > 4) chk("ce_hold_ov", 32'(out_valid), 32'(prev_ov));
      cnt++;
    end
    ce = 1'b1;

    // in_valid 1,0,1 at depth 4
    dly = DW'(4); in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      put(cnt); step("iv_fill"); cnt++;
    end
    for (int j = 0; j < 8; j++) begin
      in_valid = (j != 1);
      put(cnt); step("iv_pat"); cnt++;
      if (j >= 3 && j <= 5) chk("iv_pat_ov", 32'(out_valid), 32'(j != 4));
`ifdef DLY_PIPE_ZERO_INVALID_EN
      if (j == 4) chk("iv_zero_q", 32'(q), 32'd0);
`endif
    end
    in_valid = 1'b1;

    // Reset during FILL, then again during RUN
    dly = DW'(6);
    put(cnt); step("pre_rst_fill"); cnt++;
    put(cnt); step("pre_rst_fill"); cnt++;
    rst = 1'b1; step("rst_fill");
    chk("rst_fill_q", 32'(q), 32'd0);
    chk("rst_fill_ov", 32'(out_valid), 32'd0);
    chk("rst_fill_fl", 32'(filling), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put(cnt); step("refill"); cnt++;
      if (k == 4) chk("refill_fl5", 32'(filling), 32'd1);
      if (k == 5) chk("refill_ov6", 32'(out_valid), 32'd1);
    end
    rst = 1'b1; step("rst_run");
    chk("rst_run_q", 32'(q), 32'd0);
    chk("rst_run_ov", 32'(out_valid), 32'd0);
    chk("rst_run_fl", 32'(filling), 32'd1);
    rst = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      ce       = ($urandom % 4) != 0;
      in_valid = ($urandom % 3) != 0;
      d        = CH*W'($urandom);
      if ($urandom % 16 == 0) dly = DW'($urandom_range(0, 15));
      rst = ($urandom % 64 == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
